// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the parametrised APB memory slave.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned MAX_WAIT_CYCLES = 15;
  localparam int unsigned WAIT_CNT_W      = $clog2(MAX_WAIT_CYCLES + 1);

  function automatic int unsigned strb_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/apb_slave_param_if.sv
// APB completer-side bus bundle; the decoder/master drives the request, the slave the response.
interface apb_slave_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) ();

  localparam int unsigned STRB_W = DATA_W / 8;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W storage: byte-strobed synchronous write, asynchronous read, no reset.
module apb_mem_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] strb_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_c_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Only enabled lanes are overwritten; the rest keep their old bytes.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (strb_i[i]) begin
          mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
        end
      end
    end
  end

  assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_param.sv
// Parametrised APB memory slave: FSM, wait counter, latched request and range check.
module apb_slave_param
  import apb_slave_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic             pclk_i,
  input  logic             preset_i,
  apb_slave_param_if.slave bus
);

  localparam int unsigned STRB_W   = strb_width(DATA_W);
  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CMP_W    = ADDR_W + 1;
  localparam int unsigned CNT_W    = WAIT_CNT_W;
  localparam int unsigned WAIT_EFF = (WAIT_CYCLES > MAX_WAIT_CYCLES) ? MAX_WAIT_CYCLES : WAIT_CYCLES;

  state_e            state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic              write_q,   write_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [STRB_W-1:0] strb_q,    strb_d;
  logic              err_q,     err_d;
  logic [DATA_W-1:0] prdata_q,  prdata_d;
  logic              pready_q,  pready_d;
  logic              pslverr_q, pslverr_d;

  logic              mem_we_c;
  logic [DATA_W-1:0] mem_rdata_c;

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      err_q     <= err_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  // Next state; a setup phase is only recognised from IDLE with PENABLE low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.psel && !bus.penable) begin
          addr_d  = bus.paddr;
          write_d = bus.pwrite;
          wdata_d = bus.pwdata;
          strb_d  = bus.pstrb;
          err_d   = CMP_W'(bus.paddr) >= CMP_W'(DEPTH);
          if (WAIT_EFF == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_EFF - 1);
          end
        end
      end
      ST_WAIT: begin
        if (!bus.psel) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Response registers are loaded from the next state, so outputs stay pure flops.
  always_comb begin
    pready_d  = (state_d == ST_RESP);
    pslverr_d = (state_d == ST_RESP) && err_d;
    prdata_d  = prdata_q;
    mem_we_c  = (state_q == ST_RESP) && write_q && !err_q;
    if ((state_d == ST_RESP) && (state_q != ST_RESP) && !write_d) begin
      prdata_d = err_d ? '0 : mem_rdata_c;
    end
  end

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .STRB_W (STRB_W)
  ) u_mem (
    .clk_i     (pclk_i),
    .we_i      (mem_we_c),
    .waddr_i   (IDX_W'(addr_q)),
    .wdata_i   (wdata_q),
    .strb_i    (strb_q),
    .raddr_i   (IDX_W'(addr_d)),
    .rdata_c_o (mem_rdata_c)
  );

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_param.sv
// Scoreboard bench: two 32-bit slaves, zero-wait (dut0) and three-wait (dut1).
module tb_apb_slave_param;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 64;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  apb_slave_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  apb_slave_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  apb_slave_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .pclk_i(clk), .preset_i(rst), .bus(bus0)
  );

  apb_slave_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(3)) dut1 (
    .pclk_i(clk), .preset_i(rst), .bus(bus1)
  );

  typedef struct {
    logic        is_read;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic en, input logic w,
                       input logic [7:0] a, input logic [31:0] d, input logic [3:0] st);
    if (sel == 0) begin
      bus0.psel = s; bus0.penable = en; bus0.pwrite = w;
      bus0.paddr = a; bus0.pwdata = d; bus0.pstrb = st;
    end else begin
      bus1.psel = s; bus1.penable = en; bus1.pwrite = w;
      bus1.paddr = a; bus1.pwdata = d; bus1.pstrb = st;
    end
  endtask

  function automatic logic get_pready(input int sel);
    return (sel == 0) ? bus0.pready : bus1.pready;
  endfunction

  // Monitors: pop the oldest expectation whenever a slave completes.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (bus0.pready === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0 unexpected pready: got 1 expected 0");
      end else begin
        e = q0.pop_front();
        check("dut0 pslverr", 32'(bus0.pslverr), 32'(e.err));
        if (e.is_read) check("dut0 prdata", bus0.prdata, e.data);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (bus1.pready === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected pready: got 1 expected 0");
      end else begin
        e = q1.pop_front();
        check("dut1 pslverr", 32'(bus1.pslverr), 32'(e.err));
        if (e.is_read) check("dut1 prdata", bus1.prdata, e.data);
      end
    end
  end

  // One setup+access transfer; returns with PREADY seen (or the budget spent).
  task automatic xfer(input int sel, input logic wr, input logic [7:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic err, input logic [31:0] rdata);
    exp_t e;
    int   n;
    int   lat_exp;
    lat_exp = (sel == 0) ? 1 : 4;
    @(posedge clk); #1;
    drive(sel, 1'b1, 1'b0, wr, addr, wdata, strb);
    check($sformatf("dut%0d pready low in setup", sel), 32'(get_pready(sel)), 32'd0);
    e.is_read = !wr;
    e.err     = err;
    e.data    = rdata;
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk); #1;
    drive(sel, 1'b1, 1'b1, wr, addr, wdata, strb);
    n = 1;
    while (!get_pready(sel) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("dut%0d latency addr %0d", sel, addr), 32'(n), 32'(lat_exp));
  endtask

  task automatic idle(input int sel);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    check("dut0 reset prdata",  bus0.prdata, 32'd0);
    check("dut0 reset pready",  32'(bus0.pready), 32'd0);
    check("dut0 reset pslverr", 32'(bus0.pslverr), 32'd0);
    check("dut1 reset prdata",  bus1.prdata, 32'd0);
    check("dut1 reset pready",  32'(bus1.pready), 32'd0);
    check("dut1 reset pslverr", 32'(bus1.pslverr), 32'd0);
    rst = 1'b0;

    // Zero-wait write/read
    xfer(0, 1'b1, 8'd5, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
    xfer(0, 1'b0, 8'd5, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF);
    idle(0);

    // Byte strobes; PRDATA must hold across writes
    xfer(0, 1'b1, 8'd2, 32'h1122_3344, 4'hF, 1'b0, 32'h0);
    xfer(0, 1'b1, 8'd2, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h0);
    idle(0);
    check("dut0 prdata held over writes", bus0.prdata, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 8'd2, 32'h0, 4'h0, 1'b0, 32'h11BB_33DD);
    idle(0);

    // Out of range leaves the aliased word alone and reads zero
    xfer(0, 1'b1, 8'd6, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0);
    xfer(0, 1'b1, 8'd70, 32'h1234_5678, 4'hF, 1'b1, 32'h0);
    xfer(0, 1'b0, 8'd6, 32'h0, 4'hF, 1'b0, 32'hCAFE_F00D);
    xfer(0, 1'b0, 8'd70, 32'h0, 4'hF, 1'b1, 32'h0);
    idle(0);

    // Back-to-back alternating write/read; read with PSTRB=0
    xfer(0, 1'b1, 8'd10, 32'hA0A0_A0A0, 4'hF, 1'b0, 32'h0);
    xfer(0, 1'b0, 8'd10, 32'h0, 4'hF, 1'b0, 32'hA0A0_A0A0);
    xfer(0, 1'b1, 8'd11, 32'h0B0B_0B0B, 4'hF, 1'b0, 32'h0);
    xfer(0, 1'b0, 8'd11, 32'h0, 4'hF, 1'b0, 32'h0B0B_0B0B);
    xfer(0, 1'b0, 8'd5, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF);
    idle(0);

    // Wait states
    xfer(1, 1'b1, 8'd1, 32'h55AA_55AA, 4'hF, 1'b0, 32'h0);
    idle(1);
    xfer(1, 1'b0, 8'd1, 32'h0, 4'hF, 1'b0, 32'h55AA_55AA);
    idle(1);

    // Reset during WAIT of a write to addr 1
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 1'b1, 8'd1, 32'hFFFF_FFFF, 4'hF);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 1'b1, 8'd1, 32'hFFFF_FFFF, 4'hF);
    @(posedge clk); #1;
    check("dut1 pready low in wait", 32'(bus1.pready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("dut1 prdata cleared by reset", bus1.prdata, 32'd0);
    check("dut1 pready low in reset", 32'(bus1.pready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("dut1 access without setup ignored", 32'(bus1.pready), 32'd0);
    end
    idle(1);
    xfer(1, 1'b0, 8'd1, 32'h0, 4'hF, 1'b0, 32'h55AA_55AA);
    xfer(1, 1'b1, 8'd70, 32'h0000_0001, 4'hF, 1'b1, 32'h0);
    xfer(1, 1'b1, 8'd3, 32'h7654_3210, 4'hC, 1'b0, 32'h0);
    xfer(1, 1'b0, 8'd70, 32'h0, 4'hF, 1'b1, 32'h0);
    idle(1);

    repeat (3) @(posedge clk);
    #1;
    check("dut0 scoreboard drained", 32'(q0.size()), 32'd0);
    check("dut1 scoreboard drained", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_slave_param.md
# apb_slave_param

Parametrised APB memory-mapped slave, the successor to the fixed 8-bit/64-entry slaves on the team's APB bus. It generalises data width, address width and depth, and adds byte-lane write strobes, a configurable wait-state count, and an error response for out-of-range addresses. It sits behind the APB master/decoder, one instance per PSEL line, and its PRDATA feeds the read-data mux.

## Interface
- `DATA_W`, default 8: data width in bits; must be a multiple of 8.
- `ADDR_W`, default 8: PADDR width; PADDR is a word index, not a byte address.
- `DEPTH`, default 64: number of words; must be ≤ 2^ADDR_W.
- `WAIT_CYCLES`, default 0: extra access-phase cycles before PREADY, 0–15.
- `PCLK` in 1: single clock; all state changes on its rising edge.
- `PRESET` in 1: asynchronous, active-high reset.
- `PSEL` in 1: slave select.
- `PENABLE` in 1: access phase.
- `PWRITE` in 1: 1 = write, 0 = read.
- `PADDR` in ADDR_W: word index.
- `PWDATA` in DATA_W: write data.
- `PSTRB` in DATA_W/8: byte-lane write enables.
- `PRDATA` out DATA_W: read data, registered.
- `PREADY` out 1: transfer completion.
- `PSLVERR` out 1: error response, valid only while PREADY=1.

## Operation
- FSM states IDLE, WAIT, RESP, encoded as 2 bits.
- IDLE: when PSEL=1 and PENABLE=0 (setup phase) are sampled:
  - latch PADDR, PWRITE, PWDATA and PSTRB;
  - compute `err = (PADDR >= DEPTH)`;
  - if WAIT_CYCLES=0, go to RESP; otherwise go to WAIT with cnt=WAIT_CYCLES-1.
- WAIT: decrement cnt each cycle; go to RESP when cnt=0.
- WAIT, protocol violation: if PSEL is sampled 0, return to IDLE with no write and no response.
- RESP: PREADY=1 and PSLVERR=err; on the next edge, return to IDLE.
- Write commit, in RESP with no error: `mem[addr]` byte lane i ← PWDATA lane i where PSTRB[i]=1; other lanes unchanged.
- Write with error: memory is untouched.
- Read: PRDATA is loaded on entry to RESP.
  - No error: PRDATA ← `mem[addr]`.
  - Error: PRDATA ← 0.
  - PRDATA holds its value until the next read load.
- Read: PSTRB is ignored.
- Write: PRDATA is not updated.
- PREADY and PSLVERR are 0 in every state other than RESP.
- PSEL=1 with PENABLE=1 seen in IDLE (no setup phase): ignored; stay in IDLE.
- Back-to-back transfers: a setup phase in the cycle right after RESP is accepted, because the FSM is already in IDLE. The sustained rate is 1 transfer per (2 + WAIT_CYCLES) cycles.

## Timing
- Reset values: PREADY=0, PSLVERR=0, PRDATA=0, state=IDLE, cnt=0.
- Memory contents are not reset; reads before the first write return undefined data.
- Reset assertion mid-transfer forces IDLE immediately (asynchronously).
  - A pending write is discarded.
  - Reset has no effect on a write already committed.
- Latency, setup edge to PREADY high: 1 + WAIT_CYCLES cycles. PREADY is high in access cycle number WAIT_CYCLES+1.
- Write data is visible to a read whose setup phase starts in the cycle after RESP.
- All outputs are registered-state decodes; there is no combinational path from inputs to outputs.

## Structure
- Package `apb_slave_pkg` holds:
  - the state enum (IDLE/WAIT/RESP);
  - `STRB_W = DATA_W/8`;
  - the maximum WAIT_CYCLES constant (15).
- Sub-module `apb_mem_array` provides:
  - DEPTH × DATA_W storage with a byte-strobed synchronous write port;
  - an asynchronous read port;
  - no reset.
- The top level holds the FSM, the wait counter, the latched request and the range check.

## Test plan
- Zero-wait write then read, DATA_W=32, WAIT_CYCLES=0:
  - write addr 5, 0xDEADBEEF, PSTRB=0xF → PREADY high in the 1st access cycle, PSLVERR=0;
  - read addr 5 → PRDATA=0xDEADBEEF.
- Byte strobes: write 0x11223344 to addr 2 with PSTRB=0xF, then write 0xAABBCCDD with PSTRB=0x5 → read returns 0x11BB33DD.
- Wait states, WAIT_CYCLES=3: read → PREADY low for 3 access cycles and high in the 4th; PREADY is exactly one cycle wide.
- Out of range, DEPTH=64:
  - write addr 70 → PREADY=1 with PSLVERR=1, and addr 70 mod 64 = 6 is unchanged;
  - read addr 70 → PRDATA=0, PSLVERR=1.
- Reset mid-transfer, WAIT_CYCLES=3: assert PRESET during WAIT of a write to addr 1 → PREADY=0 at once; the old value at addr 1 is retained; the next transfer completes normally.
- Back-to-back transfers: 4 consecutive setup/access pairs with no idle cycle, alternating write and read → each completes in 2 cycles and read data matches.
